regfile_access: RTL and testbench
=================================

REGFILE_ACCESS -- requirements
Module: regfile_access

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of architectural registers swept by a dump command.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_dump in 1, cmd_addr in 5, cmd_wdata in 32: the debug command channel.
REQ-005 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_addr out 5, rsp_data out 32, rsp_err out 1, rsp_last out 1: the response channel.
REQ-006 SHALL have ports rf_write_enable out 1, rf_rd_address out 5, rf_rd_data out 32: drives the register-file write port.
REQ-007 SHALL have ports rf_rs1_address out 5, rf_rs1_data in 32: shares the register-file rs1 read port.
REQ-008 SHALL have ports core_halted in 1 (core stopped, access permitted) and busy out 1 (any state other than IDLE).

Function
REQ-009 SHALL implement FSM states IDLE, READ, WRITE, RESP, DUMP_RD, DUMP_RESP.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, and its fields are latched then.
REQ-011 SHALL leave IDLE on accept: cmd_dump=1 -> DUMP_RD with index 0 (cmd_dump takes priority over cmd_write); else cmd_write=1 -> WRITE; else READ.
REQ-012 SHALL, on any accept with core_halted=0, go straight to RESP with rsp_err=1, rsp_data=0, rsp_last=1, and perform no register-file access.
REQ-013 SHALL, in READ (one cycle), drive rf_rs1_address=latched addr, capture rf_rs1_data into rsp_data at cycle end, then go to RESP: rsp_valid rises exactly 2 cycles after accept.
REQ-014 SHALL, in WRITE (one cycle), assert rf_write_enable with rf_rd_address=addr and rf_rd_data=wdata, then go to RESP with rsp_data=wdata.
REQ-015 SHALL treat a write to address 0 as an error: rf_write_enable stays 0, rsp_err=1, rsp_data=0.
REQ-016 SHALL hold rsp_valid and all rsp_* stable in RESP until rsp_ready=1, then return to IDLE; rsp_last=1 for single reads and writes.
REQ-017 SHALL, in dump mode, alternate DUMP_RD (read index i as in REQ-013) and DUMP_RESP (hold until rsp_ready) for i = 0..NREGS-1, with rsp_addr=i and rsp_last=1 only for i=NREGS-1, then return to IDLE.
REQ-018 SHALL use a 5-bit dump index with no wrap: termination is on i==NREGS-1, never on index overflow.
REQ-019 SHALL abort a dump with rsp_err=1, rsp_last=1 at the next DUMP_RD if core_halted falls mid-dump; responses already presented complete normally.
REQ-020 SHALL drive rf_write_enable=0 in every state except WRITE, and rf_rs1_address=0 when not in READ or DUMP_RD.
REQ-021 SHALL accept rsp_ready asserted before rsp_valid; the response is consumed in the first cycle in which both are high.

Reset
REQ-022 SHALL, on reset, go to IDLE immediately and asynchronously, regardless of the current state.
REQ-023 SHALL reset every output and register to 0 (rf_write_enable, rsp_valid, busy, rsp_* and the dump index); cmd_ready becomes 1 on the first clock after reset deasserts.
REQ-024 SHALL discard an in-flight command when reset is asserted mid-operation; no pending response or write is emitted after reset.

Structure
REQ-025 SHALL place the FSM state enum and the command/response field widths in a shared package alongside the existing config and constants.
REQ-026 SHALL be a single module with no sub-modules; it connects externally to the register file's write port and its rs1 read port through a mux owned by the integrator.

Verification
REQ-027 Verification SHALL cover: halted, write x5=0xDEADBEEF -> rf_write_enable exactly 1 cycle, rsp_err=0, rsp_data=0xDEADBEEF.
REQ-028 Verification SHALL cover: halted, read x5 after that write -> rsp_valid 2 cycles after accept, rsp_data=0xDEADBEEF, rsp_last=1.
REQ-029 Verification SHALL cover: write x0=0x1234 -> no rf_write_enable, rsp_err=1; a following read of x0 returns 0.
REQ-030 Verification SHALL cover: core_halted=0, read x3 -> rsp_err=1, rf_rs1_address stays 0.
REQ-031 Verification SHALL cover: dump with rsp_ready toggling 1/0 -> 32 responses with addresses 0..31 in order, rsp_last only on 31, data matching the model.
REQ-032 Verification SHALL cover: reset asserted during DUMP_RESP at i=7 -> rsp_valid falls asynchronously, IDLE, no further responses.

Source files
------------

// File: rtl/regfile_access_pkg.sv
// Shared configuration for the debug register-file access block.
// Holds the command/response field widths, the FSM state encoding and
// a few architectural constants used by regfile_access.
package regfile_access_pkg;

  // Command / response field widths
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  // Architectural constants
  localparam int                 NREGS_DEFAULT = 32;
  localparam logic [ADDR_W-1:0]  ZERO_REG      = '0;  // x0 is hardwired to zero

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
    RESP      = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_RESP = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_access.sv
// Debug access port to the core register file.
// Accepts single read / write / dump commands while the core is halted and
// returns one response per register touched.
// Ports:
//   clock, reset        : sole clock, async active-high reset
//   cmd_*               : command channel (valid/ready, write, dump, addr, wdata)
//   rsp_*               : response channel (valid/ready, addr, data, err, last)
//   rf_write_enable, rf_rd_address, rf_rd_data : register-file write port
//   rf_rs1_address, rf_rs1_data                : shared rs1 read port
//   core_halted         : core stopped, access permitted
//   busy                : FSM not idle
module regfile_access
  import regfile_access_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_dump,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_rd_address,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic [ADDR_W-1:0] rf_rs1_address,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic              core_halted,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] idx;

  // All outputs are registered; the rf_* port values are set up on the edge
  // that enters READ/WRITE/DUMP_RD so they are valid for that whole cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      addr_q          <= '0;
      idx             <= '0;
      cmd_ready       <= 1'b0;
      busy            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_addr        <= '0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      rsp_last        <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_rd_address   <= '0;
      rf_rd_data      <= '0;
      rf_rs1_address  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            addr_q    <= cmd_addr;
            rsp_addr  <= cmd_addr;
            if (!core_halted) begin
              // Running core: refuse without touching the register file
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              rsp_last  <= 1'b1;
            end else if (cmd_dump) begin
              state          <= DUMP_RD;
              idx            <= '0;
              rf_rs1_address <= '0;
            end else if (cmd_write) begin
              state           <= WRITE;
              rf_write_enable <= (cmd_addr != ZERO_REG);
              rf_rd_address   <= cmd_addr;
              rf_rd_data      <= cmd_wdata;
            end else begin
              state          <= READ;
              rf_rs1_address <= cmd_addr;
            end
          end
        end

        READ: begin
          rsp_data       <= rf_rs1_data;
          rsp_err        <= 1'b0;
          rsp_last       <= 1'b1;
          rsp_valid      <= 1'b1;
          rf_rs1_address <= '0;
          state          <= RESP;
        end

        WRITE: begin
          rf_write_enable <= 1'b0;
          rsp_valid       <= 1'b1;
          rsp_last        <= 1'b1;
          rsp_err         <= (addr_q == ZERO_REG);
          rsp_data        <= (addr_q == ZERO_REG) ? '0 : rf_rd_data;
          state           <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        DUMP_RD: begin
          rsp_valid      <= 1'b1;
          rsp_addr       <= idx;
          rf_rs1_address <= '0;
          if (!core_halted) begin
            // Core resumed mid-dump: close the stream with an error
            rsp_err  <= 1'b1;
            rsp_last <= 1'b1;
            rsp_data <= '0;
          end else begin
            rsp_err  <= 1'b0;
            rsp_last <= (idx == LAST_IDX);
            rsp_data <= rf_rs1_data;
          end
          state <= DUMP_RESP;
        end

        DUMP_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              // Termination is decided by rsp_last, never by index overflow
              idx       <= '0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              idx            <= idx + ADDR_W'(1);
              rf_rs1_address <= idx + ADDR_W'(1);
              state          <= DUMP_RD;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access.sv
module tb_regfile_access;
  import regfile_access_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0, cmd_write = 1'b0, cmd_dump = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid, rsp_err, rsp_last;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rf_write_enable;
  logic [ADDR_W-1:0] rf_rd_address, rf_rs1_address;
  logic [DATA_W-1:0] rf_rd_data, rf_rs1_data;
  logic              core_halted = 1'b1;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  regfile_access #(.NREGS(32)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_dump(cmd_dump), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .rf_write_enable(rf_write_enable), .rf_rd_address(rf_rd_address),
    .rf_rd_data(rf_rd_data), .rf_rs1_address(rf_rs1_address),
    .rf_rs1_data(rf_rs1_data), .core_halted(core_halted), .busy(busy)
  );

  // Register file behind the access port
  logic [DATA_W-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | i;
  always @(posedge clock)
    if (rf_write_enable && rf_rd_address != 0) rf[rf_rd_address] <= rf_rd_data;
  assign rf_rs1_data = (rf_rs1_address == 0) ? '0 : rf[rf_rs1_address];

  // Expected register contents after the x5 write (x0 always 0)
  function automatic logic [31:0] exp_rf(int i);
    if (i == 0) return 32'h0;
    if (i == 5) return 32'hDEADBEEF;
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic issue(logic wr, logic dmp, logic [4:0] a, logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_dump = dmp; cmd_addr = a; cmd_wdata = d;
    tick();  // accept edge
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dump = 1'b0;
  endtask

  int n, we_cnt;
  logic done;

  initial begin
    // ---- reset state
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_we", 32'(rf_write_enable), 0);
    chk("rst_rsp_data", rsp_data, 0);
    @(negedge clock); reset = 1'b0;
    tick();
    chk("cmd_ready_after_rst", 32'(cmd_ready), 1);

    // ---- halted write x5 = DEADBEEF
    issue(1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    chk("wr_we_on", 32'(rf_write_enable), 1);
    chk("wr_rd_addr", 32'(rf_rd_address), 5);
    chk("wr_busy", 32'(busy), 1);
    chk("wr_cmd_ready", 32'(cmd_ready), 0);
    tick();
    chk("wr_we_off", 32'(rf_write_enable), 0);
    chk("wr_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_rsp_err", 32'(rsp_err), 0);
    chk("wr_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("wr_rsp_last", 32'(rsp_last), 1);
    tick(); tick();  // rsp_ready low: response must hold
    chk("wr_hold_valid", 32'(rsp_valid), 1);
    chk("wr_hold_data", rsp_data, 32'hDEADBEEF);
    rsp_ready = 1'b1;
    tick();
    chk("wr_consumed", 32'(rsp_valid), 0);
    chk("wr_idle_ready", 32'(cmd_ready), 1);
    chk("rf_x5_model", rf[5], 32'hDEADBEEF);

    // ---- read x5, rsp_ready already high before rsp_valid
    issue(1'b0, 1'b0, 5'd5, 32'h0);
    chk("rd_rs1_addr", 32'(rf_rs1_address), 5);
    chk("rd_valid_early", 32'(rsp_valid), 0);
    tick();
    chk("rd_valid_2cyc", 32'(rsp_valid), 1);
    chk("rd_data", rsp_data, 32'hDEADBEEF);
    chk("rd_last", 32'(rsp_last), 1);
    chk("rd_addr", 32'(rsp_addr), 5);
    chk("rd_rs1_idle", 32'(rf_rs1_address), 0);
    tick();
    chk("rd_consumed", 32'(rsp_valid), 0);
    tick();

    // ---- write x0 is an error and leaves x0 at zero
    issue(1'b1, 1'b0, 5'd0, 32'h1234);
    chk("wr0_we", 32'(rf_write_enable), 0);
    tick();
    chk("wr0_err", 32'(rsp_err), 1);
    chk("wr0_data", rsp_data, 0);
    tick(); tick();
    issue(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("rd0_data", rsp_data, 0);
    chk("rd0_err", 32'(rsp_err), 0);
    tick(); tick();

    // ---- core running: read x3 refused
    rsp_ready = 1'b0;
    core_halted = 1'b0;
    issue(1'b0, 1'b0, 5'd3, 32'h0);
    chk("run_rs1_addr", 32'(rf_rs1_address), 0);
    chk("run_valid", 32'(rsp_valid), 1);
    chk("run_err", 32'(rsp_err), 1);
    chk("run_data", rsp_data, 0);
    chk("run_last", 32'(rsp_last), 1);
    tick();
    chk("run_rs1_hold", 32'(rf_rs1_address), 0);
    rsp_ready = 1'b1;
    tick();
    core_halted = 1'b1;
    tick();

    // ---- full dump, rsp_ready toggling
    rsp_ready = 1'b0;
    issue(1'b0, 1'b1, 5'd9, 32'h0);
    n = 0; we_cnt = 0;
    for (int c = 0; c < 400 && n < 32; c++) begin
      rsp_ready = c[0];
      if (rf_write_enable) we_cnt++;
      if (rsp_valid && rsp_ready) begin
        chk("dump_addr", 32'(rsp_addr), n);
        chk("dump_data", rsp_data, exp_rf(n));
        chk("dump_last", 32'(rsp_last), (n == 31) ? 1 : 0);
        chk("dump_err", 32'(rsp_err), 0);
        n++;
      end
      tick();
    end
    chk("dump_count", n, 32);
    chk("dump_no_we", we_cnt, 0);
    chk("dump_idle", 32'(busy), 0);

    // ---- dump aborted when core resumes
    rsp_ready = 1'b1;
    issue(1'b0, 1'b1, 5'd0, 32'h0);
    n = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (rsp_valid) begin
        if (n == 2) begin
          chk("abort_addr", 32'(rsp_addr), 2);
          chk("abort_err", 32'(rsp_err), 1);
          chk("abort_last", 32'(rsp_last), 1);
          done = 1'b1;
        end else begin
          chk("abort_pre_err", 32'(rsp_err), 0);
          n++;
          if (n == 2) core_halted = 1'b0;
        end
      end
      tick();
    end
    chk("abort_seen", 32'(done), 1);
    chk("abort_idle", 32'(cmd_ready), 1);
    core_halted = 1'b1;
    tick();

    // ---- reset during DUMP_RESP at i=7
    issue(1'b0, 1'b1, 5'd0, 32'h0);
    n = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      rsp_ready = (n < 7);
      if (rsp_valid && rsp_addr == 7 && !rsp_ready) done = 1'b1;
      else begin
        if (rsp_valid && rsp_ready) n++;
        tick();
      end
    end
    chk("rst_mid_reached", 32'(done), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    @(negedge clock); reset = 1'b0;
    rsp_ready = 1'b1;
    n = 0; we_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rsp_valid) n++;
      if (rf_write_enable) we_cnt++;
    end
    chk("rst_mid_no_rsp", n, 0);
    chk("rst_mid_no_we", we_cnt, 0);
    chk("rst_mid_ready", 32'(cmd_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
